// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - synchronise, debounce and condition note/length/button switches
// Optional auto-repeat on oct_up/oct_down: define KEY_CONDITIONER_REPEAT_EN.
module key_conditioner #(
    parameter int TICK_CYCLES    = 100000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] raw_note,
    input  logic [6:0] raw_len,
    input  logic [3:0] raw_btn,
    output logic [6:0] note_key,
    output logic [6:0] length_key,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic       multi_key,
    output logic       tick
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 31 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_conditioner: illegal parameter value");
    end

    logic [17:0]   raw_all;
    logic [17:0]   sync1;
    logic [17:0]   sync2;
    logic [17:0]   stable;
    logic [4:0]    db_cnt [18];
    logic [TW-1:0] tick_cnt;
    logic [3:0]    btn_prev;
    logic [3:0]    rep_fire;
    logic [6:0]    note_v;
    logic [6:0]    len_v;

    assign raw_all = {raw_btn, raw_len, raw_note};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_all;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= (tick_cnt == TW'(TICK_CYCLES - 1));
            if (tick_cnt == TW'(TICK_CYCLES - 1))
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Counter tracks consecutive ticks on which the input disagreed with the accepted level.
    for (genvar c = 0; c < 18; c++) begin : g_chan
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stable[c] <= 1'b0;
                db_cnt[c] <= '0;
            end else if (tick) begin
                if (sync2[c] == stable[c]) begin
                    db_cnt[c] <= '0;
                end else if (db_cnt[c] == 5'(DEBOUNCE_TICKS - 1)) begin
                    stable[c] <= ~stable[c];
                    db_cnt[c] <= '0;
                end else begin
                    db_cnt[c] <= db_cnt[c] + 5'd1;
                end
            end
        end
    end

    assign note_v     = stable[6:0];
    assign len_v      = stable[13:7];
    assign btn_level  = stable[17:14];
    assign multi_key  = ((note_v & (note_v - 7'd1)) != 7'd0);
    assign note_key   = ((note_v != 7'd0) && !multi_key) ? note_v : 7'd0;
    assign length_key = ((len_v != 7'd0) && ((len_v & (len_v - 7'd1)) == 7'd0)) ? len_v : 7'd0;

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int PW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD + 1) : 1;

    logic [HW-1:0] hold [2];
    logic [PW-1:0] per  [2];

    // hold saturates at REPEAT_DELAY; per then paces the periodic repeats.
    always_comb begin
        rep_fire = 4'b0;
        for (int j = 0; j < 2; j++) begin
            if (tick && btn_level[j+2]) begin
                if (hold[j] != HW'(REPEAT_DELAY))
                    rep_fire[j+2] = (hold[j] == HW'(REPEAT_DELAY - 1));
                else
                    rep_fire[j+2] = (per[j] == PW'(REPEAT_PERIOD - 1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                hold[j] <= '0;
                per[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!btn_level[j+2]) begin
                    hold[j] <= '0;
                    per[j]  <= '0;
                end else if (tick) begin
                    if (hold[j] != HW'(REPEAT_DELAY))
                        hold[j] <= hold[j] + 1'b1;
                    else if (per[j] == PW'(REPEAT_PERIOD - 1))
                        per[j] <= '0;
                    else
                        per[j] <= per[j] + 1'b1;
                end
            end
        end
    end
`else
    assign rep_fire = 4'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev  <= '0;
            btn_pulse <= '0;
        end else begin
            btn_prev  <= btn_level;
            btn_pulse <= (btn_level & ~btn_prev) | rep_fire;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed bench with cycle model for key_conditioner
module tb_key_conditioner;

    localparam int T  = 10;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] raw_note = '0;
    logic [6:0] raw_len = '0;
    logic [3:0] raw_btn = '0;
    logic [6:0] note_key;
    logic [6:0] length_key;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic       multi_key;
    logic       tick;

    int n_checks = 0;
    int n_fail = 0;

    key_conditioner #(
        .TICK_CYCLES(T), .DEBOUNCE_TICKS(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raw_note(raw_note), .raw_len(raw_len), .raw_btn(raw_btn),
        .note_key(note_key), .length_key(length_key), .btn_level(btn_level),
        .btn_pulse(btn_pulse), .multi_key(multi_key), .tick(tick)
    );

    always #5 clk = ~clk;

    // Model state: edge count since reset, raw history, accepted levels, tick sample windows.
    int          m_n = 0;
    logic [17:0] m_rh1 = '0;
    logic [17:0] m_rh2 = '0;
    logic [17:0] m_st = '0;
    logic [3:0]  m_prev = '0;
    logic [3:0]  m_pulse = '0;
    logic        m_tick = 1'b0;
    logic [31:0] m_hist [18];
    int          m_nv [18];
    int          m_hold [4];

    task automatic model_clear();
        m_n = 0; m_rh1 = '0; m_rh2 = '0; m_st = '0; m_prev = '0; m_pulse = '0; m_tick = 1'b0;
        for (int c = 0; c < 18; c++) begin m_hist[c] = '0; m_nv[c] = 0; end
        for (int b = 0; b < 4; b++) m_hold[b] = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                logic [17:0] sync;
                logic [3:0]  lvl_pre;
                logic        tick_pre;
                logic        all_diff;
                m_n++;
                sync     = m_rh2;
                tick_pre = ((m_n - 1) >= T) && (((m_n - 1) % T) == 0);
                lvl_pre  = m_st[17:14];
                m_pulse  = lvl_pre & ~m_prev;
`ifdef KEY_CONDITIONER_REPEAT_EN
                for (int b = 2; b < 4; b++) begin
                    if (!lvl_pre[b]) m_hold[b] = 0;
                    else if (tick_pre) begin
                        m_hold[b]++;
                        if (m_hold[b] == RD || (m_hold[b] > RD && ((m_hold[b] - RD) % RP) == 0))
                            m_pulse[b] = 1'b1;
                    end
                end
`endif
                m_prev = lvl_pre;
                if (tick_pre) begin
                    for (int c = 0; c < 18; c++) begin
                        m_hist[c] = {m_hist[c][30:0], sync[c]};
                        if (m_nv[c] < 32) m_nv[c]++;
                        if (m_nv[c] >= D) begin
                            all_diff = 1'b1;
                            for (int k = 0; k < D; k++)
                                if (m_hist[c][k] == m_st[c]) all_diff = 1'b0;
                            if (all_diff) m_st[c] = ~m_st[c];
                        end
                    end
                end
                m_rh2  = m_rh1;
                m_rh1  = {raw_btn, raw_len, raw_note};
                m_tick = ((m_n % T) == 0);
            end
        end
    end

    function automatic logic [6:0] onehot_or_zero(input logic [6:0] v);
        return ($countones(v) == 1) ? v : 7'd0;
    endfunction

    initial begin
        forever begin
            logic [29:0] exp_v;
            logic [29:0] act_v;
            @(negedge clk);
            exp_v = {onehot_or_zero(m_st[6:0]), onehot_or_zero(m_st[13:7]), m_st[17:14], m_pulse,
                     ($countones(m_st[6:0]) >= 2), m_tick};
            act_v = {note_key, length_key, btn_level, btn_pulse, multi_key, tick};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
        end
    end

    int         pc [4];
    logic [3:0] first_pulse = '0;
    logic       note_seen = 1'b0;

    initial begin
        for (int b = 0; b < 4; b++) pc[b] = 0;
        forever begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) if (btn_pulse[b]) pc[b]++;
            if (btn_pulse != 4'b0 && first_pulse == 4'b0) first_pulse = btn_pulse;
            if (note_key != 7'd0 || multi_key) note_seen = 1'b1;
        end
    end

    task automatic clear_mon();
        for (int b = 0; b < 4; b++) pc[b] = 0;
        first_pulse = '0;
        note_seen = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {note_key, length_key, btn_level, btn_pulse, multi_key, tick}, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(20);

        clear_mon();
        raw_btn = 4'b0001;
        lat = 0;
        while (!btn_level[0] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("btn0_latency_window", (lat >= 32 && lat <= 52), 1);
        step(10);
        check("btn0_single_pulse", pc[0], 1);
        raw_btn = 4'b0000;
        step(80);
        check("btn0_no_release_pulse", pc[0], 1);
        check("btn0_level_released", btn_level, 4'b0000);

        clear_mon();
        raw_note = 7'b0000100;
        step(20);
        raw_note = 7'b0000000;
        step(80);
        check("glitch_no_note", note_seen, 0);

        raw_note = 7'b0000101;
        step(80);
        check("two_notes_key", note_key, 7'b0000000);
        check("two_notes_multi", multi_key, 1);
        raw_note = 7'b0000100;
        step(80);
        check("one_note_key", note_key, 7'b0000100);
        check("one_note_multi", multi_key, 0);
        raw_note = 7'b0000000;
        step(80);

        clear_mon();
        raw_btn = 4'b0011;
        step(80);
        check("dual_press_first_pulse", first_pulse, 4'b0011);
        check("dual_press_count0", pc[0], 1);
        check("dual_press_count1", pc[1], 1);
        raw_btn = 4'b0000;
        step(80);

        clear_mon();
        raw_btn = 4'b0001;
        step(25);
        rst_n = 1'b0;
        @(negedge clk);
        check("midpress_reset_outputs", {note_key, length_key, btn_level, btn_pulse, multi_key, tick}, 32'd0);
        step(2);
        check("midpress_no_pulse", pc[0], 0);
        rst_n = 1'b1;
        step(80);
        check("post_reset_single_pulse", pc[0], 1);
        check("post_reset_level", btn_level[0], 1);
        raw_btn = 4'b0000;
        step(80);

        clear_mon();
        raw_btn = 4'b0100;
        step(260);
`ifdef KEY_CONDITIONER_REPEAT_EN
        check("oct_up_repeat_pulses", pc[2], 6);
`else
        check("oct_up_repeat_pulses", pc[2], 1);
`endif
        raw_btn = 4'b0000;
        step(120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
